// File: rtl/decomp_pkg.sv
// Shared encodings, widths and FSM states for the decompressor front-end scheduler.
// Also provides the CoN legality screen used before issue.
package decomp_pkg;

  localparam int CW = 260;
  localparam int LW = 256;

  typedef enum logic [3:0] {
    ZERO   = 4'd0,
    B8D1   = 4'd1,
    B8D2   = 4'd2,
    B8D4   = 4'd3,
    B4D1   = 4'd4,
    B4D2   = 4'd5,
    B2D1   = 4'd6,
    REP    = 4'd7,
    UNCOMP = 4'd8
  } con_e;

  localparam logic [3:0] CON_MAX = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ERR   = 2'd2
  } state_e;

  function automatic logic con_legal(input logic [3:0] con);
    return (con <= CON_MAX);
  endfunction

endpackage

// File: rtl/decomp_sched_rr_arbiter.sv
// Round-robin arbiter: scans upward from ptr+1 (mod N) and grants the first
// asserted request, returning both a one-hot grant and its index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_id
);

  logic         found_s;
  logic [N-1:0] mask_s;
  int           idx_s;

  // Rotating priority scan; the first hit after ptr wins.
  always_comb begin
    grant    = {N{1'b0}};
    grant_id = {PW{1'b0}};
    found_s  = 1'b0;
    mask_s   = {N{1'b0}};
    idx_s    = 0;
    for (int k = 1; k <= N; k++) begin
      idx_s  = (int'(ptr) + k) % N;
      mask_s = {{(N-1){1'b0}}, 1'b1} << idx_s;
      if (!found_s && ((req & mask_s) != {N{1'b0}})) begin
        found_s  = 1'b1;
        grant    = mask_s;
        grant_id = PW'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/decomp_sched.sv
// Shares one decompressor between NUM_REQ requesters: round-robin issue,
// in-order ID tracking for responses, and in-order error replies for bad CoN.
module decomp_sched #(
  parameter int NUM_REQ = 2,
  parameter int MAX_OUT = 4,
  parameter int CW      = decomp_pkg::CW,
  parameter int LW      = decomp_pkg::LW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*CW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  dec_valid,
  output logic [CW-1:0]         dec_data,
  input  logic                  dec_ready,
  input  logic                  dec_out_valid,
  input  logic [LW-1:0]         dec_line,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [LW-1:0]         rsp_line,
  output logic                  rsp_err,
  output logic [31:0]           lines_done,
  output logic [15:0]           err_cnt
);

  import decomp_pkg::state_e;
  import decomp_pkg::IDLE;
  import decomp_pkg::ISSUE;
  import decomp_pkg::ERR;
  import decomp_pkg::con_legal;

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int AW   = $clog2(MAX_OUT);
  localparam int CNTW = AW + 1;

  state_e               state_r, state_s;
  logic [IDW-1:0]       ptr_r, grant_id_s, issue_id_r;
  logic [NUM_REQ-1:0]   grant_s, req_ready_s;
  logic [CW-1:0]        entry_s [NUM_REQ];
  logic [CW-1:0]        sel_data_s, dec_data_r;
  logic                 dec_valid_r, accept_s, push_s, pop_s, err_fire_s;
  logic                 fifo_full_s, fifo_empty_s;
  logic [IDW-1:0]       fifo_mem_r [MAX_OUT];
  logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [CNTW-1:0]      count_r;
  logic [NUM_REQ-1:0]   rsp_valid_r;
  logic [LW-1:0]        rsp_line_r;
  logic                 rsp_err_r;
  logic [31:0]          lines_done_r;
  logic [15:0]          err_cnt_r;

  function automatic logic [NUM_REQ-1:0] id_onehot(input logic [IDW-1:0] id);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << id;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_entry
    assign entry_s[g] = req_data[g*CW +: CW];
  end

  rr_arbiter #(.N(NUM_REQ), .PW(IDW)) u_arb (
    .req      (req_valid),
    .ptr      (ptr_r),
    .grant    (grant_s),
    .grant_id (grant_id_s)
  );

  assign sel_data_s   = entry_s[grant_id_s];
  assign fifo_full_s  = (count_r == CNTW'(MAX_OUT));
  assign fifo_empty_s = (count_r == {CNTW{1'b0}});
  assign pop_s        = dec_out_valid & ~fifo_empty_s;

  // Next-state logic; accept is gated by reset so req_ready stays low in reset.
  always_comb begin
    state_s     = state_r;
    accept_s    = 1'b0;
    push_s      = 1'b0;
    err_fire_s  = 1'b0;
    req_ready_s = {NUM_REQ{1'b0}};
    case (state_r)
      IDLE: begin
        if ((grant_s != {NUM_REQ{1'b0}}) && !fifo_full_s && !rst) begin
          accept_s    = 1'b1;
          req_ready_s = grant_s;
          state_s     = con_legal(sel_data_s[3:0]) ? ISSUE : ERR;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (dec_ready) begin
          push_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = ISSUE;
        end
      end
      ERR: begin
        // Error reply waits behind every outstanding line to keep order.
        if (fifo_empty_s) begin
          err_fire_s = 1'b1;
          state_s    = IDLE;
        end else begin
          state_s = ERR;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM, round-robin pointer and issue register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= IDW'(NUM_REQ - 1);
      issue_id_r  <= {IDW{1'b0}};
      dec_data_r  <= {CW{1'b0}};
      dec_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      dec_valid_r <= (state_s == ISSUE);
      if (accept_s) begin
        ptr_r      <= grant_id_s;
        issue_id_r <= grant_id_s;
        dec_data_r <= sel_data_s;
      end
    end
  end

  // In-order ID FIFO of requests inside the decompressor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNTW{1'b0}};
      for (int i = 0; i < MAX_OUT; i++) begin
        fifo_mem_r[i] <= {IDW{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= issue_id_r;
        wr_ptr_r             <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNTW'(1);
        2'b01:   count_r <= count_r - CNTW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered response port and statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r  <= {NUM_REQ{1'b0}};
      rsp_line_r   <= {LW{1'b0}};
      rsp_err_r    <= 1'b0;
      lines_done_r <= 32'd0;
      err_cnt_r    <= 16'd0;
    end else if (pop_s) begin
      rsp_valid_r  <= id_onehot(fifo_mem_r[rd_ptr_r]);
      rsp_line_r   <= dec_line;
      rsp_err_r    <= 1'b0;
      lines_done_r <= lines_done_r + 32'd1;
    end else if (err_fire_s) begin
      rsp_valid_r <= id_onehot(issue_id_r);
      rsp_line_r  <= {LW{1'b0}};
      rsp_err_r   <= 1'b1;
      if (err_cnt_r != 16'hFFFF) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end
    end else begin
      rsp_valid_r <= {NUM_REQ{1'b0}};
      rsp_err_r   <= 1'b0;
    end
  end

  assign req_ready  = req_ready_s;
  assign dec_valid  = dec_valid_r;
  assign dec_data   = dec_data_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_line   = rsp_line_r;
  assign rsp_err    = rsp_err_r;
  assign lines_done = lines_done_r;
  assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_decomp_sched.sv
// Directed bench for decomp_sched: a table of isolated requests, then
// hand-written sequences for fairness, backpressure, full FIFO, errors and reset.
module tb_decomp_sched;
  import decomp_pkg::*;

  typedef logic [259:0] w_t;

  typedef struct {
    int         rid;
    logic [3:0] con;
    logic [31:0] seed;
    logic [31:0] lseed;
    bit         legal;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [2*CW-1:0] req_data;
  logic [1:0]    req_ready;
  logic          dec_valid;
  logic [CW-1:0] dec_data;
  logic          dec_ready;
  logic          dec_out_valid;
  logic [LW-1:0] dec_line;
  logic [1:0]    rsp_valid;
  logic [LW-1:0] rsp_line;
  logic          rsp_err;
  logic [31:0]   lines_done;
  logic [15:0]   err_cnt;

  logic [CW-1:0] ent [2];
  assign req_data = {ent[1], ent[0]};

  int n_tests = 0;
  int n_fail  = 0;
  int exp_lines = 0;
  int exp_err   = 0;

  decomp_sched #(.NUM_REQ(2), .MAX_OUT(4), .CW(CW), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .dec_valid(dec_valid), .dec_data(dec_data), .dec_ready(dec_ready),
    .dec_out_valid(dec_out_valid), .dec_line(dec_line),
    .rsp_valid(rsp_valid), .rsp_line(rsp_line), .rsp_err(rsp_err),
    .lines_done(lines_done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] mk_entry(input logic [3:0] con, input logic [31:0] seed);
    return {{8{seed}}, con};
  endfunction

  function automatic logic [LW-1:0] mk_line(input logic [31:0] seed);
    return {8{seed}};
  endfunction

  task automatic chk(input string name, input w_t act, input w_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Call at a negedge; samples req_ready until a grant appears or the budget runs out.
  task automatic wait_grant(input logic [1:0] exp, input string name);
    bit seen = 1'b0;
    #1;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (req_ready != 2'b00) seen = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    chk(name, w_t'(req_ready), w_t'(exp));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"},  w_t'(req_ready),  w_t'(0));
    chk({tag, "_dec_valid"},  w_t'(dec_valid),  w_t'(0));
    chk({tag, "_dec_data"},   w_t'(dec_data),   w_t'(0));
    chk({tag, "_rsp_valid"},  w_t'(rsp_valid),  w_t'(0));
    chk({tag, "_rsp_line"},   w_t'(rsp_line),   w_t'(0));
    chk({tag, "_rsp_err"},    w_t'(rsp_err),    w_t'(0));
    chk({tag, "_lines_done"}, w_t'(lines_done), w_t'(0));
    chk({tag, "_err_cnt"},    w_t'(err_cnt),    w_t'(0));
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    vec_t vecs [6];
    logic [1:0] oh;
    int extra;

    vecs[0] = '{rid: 0, con: 4'd7, seed: 32'h1111_0007, lseed: 32'hA0A0_0001, legal: 1'b1};
    vecs[1] = '{rid: 1, con: 4'd0, seed: 32'h2222_0000, lseed: 32'hA0A0_0002, legal: 1'b1};
    vecs[2] = '{rid: 0, con: 4'd8, seed: 32'h3333_0008, lseed: 32'hA0A0_0003, legal: 1'b1};
    vecs[3] = '{rid: 1, con: 4'd9, seed: 32'h4444_0009, lseed: 32'hA0A0_0004, legal: 1'b0};
    vecs[4] = '{rid: 0, con: 4'hF, seed: 32'h5555_000F, lseed: 32'hA0A0_0005, legal: 1'b0};
    vecs[5] = '{rid: 1, con: 4'd3, seed: 32'h6666_0003, lseed: 32'hA0A0_0006, legal: 1'b1};

    rst = 1'b1; req_valid = 2'b00; ent[0] = '0; ent[1] = '0;
    dec_ready = 1'b1; dec_out_valid = 1'b0; dec_line = '0;
    #3;
    chk_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Table: isolated requests, one at a time.
    foreach (vecs[v]) begin
      oh = 2'b01 << vecs[v].rid;
      @(negedge clk);
      ent[vecs[v].rid] = mk_entry(vecs[v].con, vecs[v].seed);
      req_valid = oh;
      wait_grant(oh, "tbl_grant");
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      if (vecs[v].legal) begin
        chk("tbl_dec_valid", w_t'(dec_valid), w_t'(1));
        chk("tbl_dec_data", w_t'(dec_data), w_t'(mk_entry(vecs[v].con, vecs[v].seed)));
        @(negedge clk);
        dec_out_valid = 1'b1;
        dec_line = mk_line(vecs[v].lseed);
        #1;
        chk("tbl_dec_valid_drop", w_t'(dec_valid), w_t'(0));
        @(negedge clk);
        dec_out_valid = 1'b0;
        #1;
        exp_lines++;
        chk("tbl_rsp_valid", w_t'(rsp_valid), w_t'(oh));
        chk("tbl_rsp_line", w_t'(rsp_line), w_t'(mk_line(vecs[v].lseed)));
        chk("tbl_rsp_err", w_t'(rsp_err), w_t'(0));
        chk("tbl_lines_done", w_t'(lines_done), w_t'(exp_lines));
      end else begin
        chk("tbl_err_no_issue", w_t'(dec_valid), w_t'(0));
        @(negedge clk);
        #1;
        exp_err++;
        chk("tbl_err_rsp_valid", w_t'(rsp_valid), w_t'(oh));
        chk("tbl_err_rsp_err", w_t'(rsp_err), w_t'(1));
        chk("tbl_err_rsp_line", w_t'(rsp_line), w_t'(0));
        chk("tbl_err_cnt", w_t'(err_cnt), w_t'(exp_err));
      end
      @(negedge clk);
      #1;
      chk("tbl_rsp_pulse", w_t'(rsp_valid), w_t'(0));
    end

    // Fairness: both requesters held, responses drained continuously.
    @(negedge clk);
    ent[0] = mk_entry(4'd1, 32'h0F0F_0001);
    ent[1] = mk_entry(4'd2, 32'h0F0F_0002);
    req_valid = 2'b11;
    dec_out_valid = 1'b1;
    dec_line = mk_line(32'hFA1E_0000);
    for (int g = 0; g < 8; g++) begin
      oh = 2'b01 << (g % 2);
      wait_grant(oh, "fair_grant");
      @(negedge clk);
    end
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    dec_out_valid = 1'b0;
    #1;
    exp_lines += 8;
    chk("fair_lines_done", w_t'(lines_done), w_t'(exp_lines));

    // Backpressure: dec_ready low for 5 cycles during ISSUE.
    @(negedge clk);
    dec_ready = 1'b0;
    ent[0] = mk_entry(4'd4, 32'hB00B_0000);
    ent[1] = mk_entry(4'd5, 32'hB00B_0001);
    req_valid = 2'b11;
    wait_grant(2'b01, "bp_grant0");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 2'b10;
      #1;
      chk("bp_dec_valid", w_t'(dec_valid), w_t'(1));
      chk("bp_dec_data", w_t'(dec_data), w_t'(mk_entry(4'd4, 32'hB00B_0000)));
      chk("bp_no_ready", w_t'(req_ready), w_t'(0));
      if (i == 4) dec_ready = 1'b1;
    end
    @(negedge clk);
    #1;
    chk("bp_grant1", w_t'(req_ready), w_t'(2'b10));
    @(negedge clk);
    req_valid = 2'b00;
    dec_out_valid = 1'b1;
    dec_line = mk_line(32'hCAFE_0001);
    @(negedge clk);
    dec_line = mk_line(32'hCAFE_0002);
    #1;
    chk("bp_rsp0_valid", w_t'(rsp_valid), w_t'(2'b01));
    chk("bp_rsp0_line", w_t'(rsp_line), w_t'(mk_line(32'hCAFE_0001)));
    @(negedge clk);
    dec_out_valid = 1'b0;
    #1;
    chk("bp_rsp1_valid", w_t'(rsp_valid), w_t'(2'b10));
    chk("bp_rsp1_line", w_t'(rsp_line), w_t'(mk_line(32'hCAFE_0002)));
    exp_lines += 2;
    chk("bp_lines_done", w_t'(lines_done), w_t'(exp_lines));

    // Full FIFO: four issues with no responses, fifth grant withheld.
    @(negedge clk);
    ent[0] = mk_entry(4'd6, 32'hF011_0000);
    req_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      wait_grant(2'b01, "full_grant");
      @(negedge clk);
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (req_ready != 2'b00) extra++;
    end
    chk("full_withheld", w_t'(extra), w_t'(0));
    @(negedge clk);
    dec_out_valid = 1'b1;
    dec_line = mk_line(32'hF011_00C0);
    #1;
    chk("full_still_withheld", w_t'(req_ready), w_t'(0));
    @(negedge clk);
    dec_out_valid = 1'b0;
    wait_grant(2'b01, "full_regrant");
    chk("full_rsp_valid", w_t'(rsp_valid), w_t'(2'b01));
    chk("full_rsp_line", w_t'(rsp_line), w_t'(mk_line(32'hF011_00C0)));
    @(negedge clk);
    req_valid = 2'b00;
    for (int j = 0; j < 4; j++) begin
      dec_out_valid = 1'b1;
      dec_line = mk_line(32'hD0D0_0000 + j);
      @(negedge clk);
      #1;
      chk("full_drain_valid", w_t'(rsp_valid), w_t'(2'b01));
      chk("full_drain_line", w_t'(rsp_line), w_t'(mk_line(32'hD0D0_0000 + j)));
    end
    @(negedge clk);
    #1;
    chk("full_empty_ignore", w_t'(rsp_valid), w_t'(0));
    dec_out_valid = 1'b0;
    exp_lines += 5;
    chk("full_lines_done", w_t'(lines_done), w_t'(exp_lines));

    // Illegal encoding behind two outstanding requests.
    @(negedge clk);
    ent[0] = mk_entry(4'd5, 32'h1E6A_0000);
    req_valid = 2'b01;
    wait_grant(2'b01, "ill_pre_grant");
    @(negedge clk);
    wait_grant(2'b01, "ill_pre_grant");
    @(negedge clk);
    ent[1] = mk_entry(4'hA, 32'h1E6A_000A);
    req_valid = 2'b10;
    wait_grant(2'b10, "ill_grant");
    @(negedge clk);
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ill_no_issue", w_t'(dec_valid), w_t'(0));
      chk("ill_no_rsp", w_t'(rsp_valid), w_t'(0));
      @(negedge clk);
    end
    dec_out_valid = 1'b1;
    dec_line = mk_line(32'h0DD0_0001);
    @(negedge clk);
    dec_line = mk_line(32'h0DD0_0002);
    #1;
    chk("ill_rsp_a_valid", w_t'(rsp_valid), w_t'(2'b01));
    chk("ill_rsp_a_line", w_t'(rsp_line), w_t'(mk_line(32'h0DD0_0001)));
    chk("ill_rsp_a_err", w_t'(rsp_err), w_t'(0));
    @(negedge clk);
    dec_out_valid = 1'b0;
    #1;
    chk("ill_rsp_b_valid", w_t'(rsp_valid), w_t'(2'b01));
    chk("ill_rsp_b_line", w_t'(rsp_line), w_t'(mk_line(32'h0DD0_0002)));
    @(negedge clk);
    #1;
    exp_err++;
    exp_lines += 2;
    chk("ill_err_valid", w_t'(rsp_valid), w_t'(2'b10));
    chk("ill_err_flag", w_t'(rsp_err), w_t'(1));
    chk("ill_err_line", w_t'(rsp_line), w_t'(0));
    chk("ill_err_cnt", w_t'(err_cnt), w_t'(exp_err));
    chk("ill_lines_done", w_t'(lines_done), w_t'(exp_lines));

    // Reset with requests in flight, then a stray decompressor output.
    @(negedge clk);
    ent[0] = mk_entry(4'd2, 32'h5E5E_0000);
    req_valid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      wait_grant(2'b01, "rst_pre_grant");
      @(negedge clk);
    end
    dec_out_valid = 1'b1;
    dec_line = mk_line(32'h5E5E_1111);
    @(negedge clk);
    dec_out_valid = 1'b0;
    #1;
    chk("rst_pre_rsp", w_t'(rsp_valid), w_t'(2'b01));
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    dec_out_valid = 1'b1;
    dec_line = mk_line(32'h57A7_0000);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_stray_rsp", w_t'(rsp_valid), w_t'(0));
    end
    dec_out_valid = 1'b0;
    chk("rst_lines_done", w_t'(lines_done), w_t'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
